md_unit_v2: RTL and testbench

Parametrised multiply/divide unit for the E stage of the pipelined MIPS core, owning the HI/LO register pair. Supports signed and unsigned mult/div, multiply-accumulate (madd/maddu/msub/msubu), mthi/mtlo writes and mfhi/mflo reads. Latencies are configurable. The unit has an explicit start/busy handshake and a flush input so the core can cancel an in-flight operation on an exception.

---
 rtl/md_unit_v2.sv | 175 +++++++++++++++++
 tb/tb_md_unit_v2.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/md_unit_v2.sv
// md_unit_v2: multiply/divide unit for the E stage, owner of the HI/LO pair.
// The arithmetic result is computed at accept time into temporary registers.
// HI/LO are written from those registers after a configurable busy window,
// unless a flush cancels the operation before the write.
//
// Ports:
//   clk     clock, rising edge
//   reset   synchronous, active-high; overrides start and flush
//   start   op is valid this cycle
//   op      0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo,
//           8 madd, 9 maddu, 10 msub, 11 msubu, 12-15 nop
//   src_a   rs operand
//   src_b   rt operand
//   flush   cancel in-flight operation (and block any start this cycle)
//   busy    arithmetic operation in progress
//   result  mfhi/mflo read data (combinational, 0 for other ops)
//   hi_q    current HI
//   lo_q    current LO
//
// state  | meaning
// S_IDLE | no operation in flight; accepts start, mthi/mtlo write directly
// S_BUSY | counter running; HI/LO written from temps when counter expires

module md_unit_v2 #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  hi, lo;
    logic [WIDTH-1:0]  tmp_hi, tmp_lo;
    logic              tmp_wr;

    logic                  is_signed, is_mul, is_div, div_zero;
    logic [2*WIDTH-1:0]    ext_a, ext_b, prod, mul_res;
    logic                  a_neg, b_neg;
    logic [WIDTH-1:0]      abs_a, abs_b, div_b, uq, ur, quo, rem;

    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
        is_mul    = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                    (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
        is_div    = (op == OP_DIV) || (op == OP_DIVU);
        div_zero  = (src_b == '0);

        // Sign- or zero-extend to 2*WIDTH; the truncated product is then
        // correct for both signed and unsigned operands.
        ext_a = is_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
        ext_b = is_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
        prod  = ext_a * ext_b;

        case (op)
            OP_MADD, OP_MADDU: mul_res = {hi, lo} + prod;
            OP_MSUB, OP_MSUBU: mul_res = {hi, lo} - prod;
            default:           mul_res = prod;
        endcase

        // Signed division via magnitudes. MIN / -1 falls out naturally:
        // |MIN| = MIN as unsigned, quotient negates back to MIN, remainder 0.
        a_neg = is_signed && src_a[WIDTH-1];
        b_neg = is_signed && src_b[WIDTH-1];
        abs_a = a_neg ? -src_a : src_a;
        abs_b = b_neg ? -src_b : src_b;
        div_b = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
        uq    = abs_a / div_b;
        ur    = abs_a % div_b;
        quo   = (a_neg ^ b_neg) ? -uq : uq;
        rem   = a_neg ? -ur : ur;
    end

    always_comb begin
        result = '0;
        if (op == OP_MFHI) result = hi;
        else if (op == OP_MFLO) result = lo;
    end

    assign hi_q = hi;
    assign lo_q = lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            tmp_hi <= '0;
            tmp_lo <= '0;
            tmp_wr <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        if (is_mul) begin
                            {tmp_hi, tmp_lo} <= mul_res;
                            tmp_wr <= 1'b1;
                            cnt    <= MULT_N;
                            state  <= S_BUSY;
                            busy   <= 1'b1;
                        end else if (is_div) begin
                            tmp_hi <= rem;
                            tmp_lo <= quo;
                            tmp_wr <= !div_zero;
                            cnt    <= DIV_N;
                            state  <= S_BUSY;
                            busy   <= 1'b1;
                        end else if (op == OP_MTHI) begin
                            hi <= src_a;
                        end else if (op == OP_MTLO) begin
                            lo <= src_a;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == CNT_ONE) begin
                        if (tmp_wr) begin
                            hi <= tmp_hi;
                            lo <= tmp_lo;
                        end
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_v2.sv
// Directed bench for md_unit_v2 with hand-computed expected values.
// Tasks begin and end aligned to a falling edge; inputs change there and
// outputs are sampled there (or #1 later after changing op for mf* reads).

module tb_md_unit_v2;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [3:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy;
    logic [31:0] result, hi_q, lo_q;

    int checks = 0;
    int errors = 0;

    md_unit_v2 #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .busy   (busy),
        .result (result),
        .hi_q   (hi_q),
        .lo_q   (lo_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one op for one cycle; returns at the falling edge after the
    // accepting rising edge with start deasserted.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; op = 4'd15;
    endtask

    // Counts falling-edge samples with busy high, bounded.
    task automatic wait_idle(input string tag, input int exp_n);
        int n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(tag, n, exp_n);
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        check({tag, "_hi"}, hi_q, eh);
        check({tag, "_lo"}, lo_q, el);
    endtask

    task automatic read_mf(input string tag, input logic [3:0] o, input logic [31:0] exp);
        op = o;
        #1;
        check(tag, result, exp);
        op = 4'd15;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 4'd15; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        // reset overrides start
        start = 1'b1; op = 4'd6; src_a = 32'hAAAA;
        @(negedge clk);
        start = 1'b0; op = 4'd15;
        reset = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check_hilo("rst", 32'h0, 32'h0);
        read_mf("rst_mfhi", 4'd4, 32'h0);

        // mthi / mtlo / mf reads
        issue(4'd6, 32'h1234, 32'h0);
        check("mthi_busy", {31'b0, busy}, 32'h0);
        issue(4'd7, 32'h5678, 32'h0);
        check("mtlo_busy", {31'b0, busy}, 32'h0);
        read_mf("mfhi", 4'd4, 32'h1234);
        read_mf("mflo", 4'd5, 32'h5678);
        read_mf("nop_result", 4'd12, 32'h0);

        // nop op and flush-with-start do nothing
        issue(4'd13, 32'hFFFF, 32'h3);
        check("nop_busy", {31'b0, busy}, 32'h0);
        flush = 1'b1;
        issue(4'd0, 32'h3, 32'h3);
        flush = 1'b0;
        check("flush_start_busy", {31'b0, busy}, 32'h0);
        check_hilo("flush_start", 32'h1234, 32'h5678);

        // mult / multu
        issue(4'd0, 32'hFFFFFFFF, 32'h2);
        wait_idle("mult_cycles", 5);
        check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);
        issue(4'd1, 32'hFFFFFFFF, 32'h2);
        wait_idle("multu_cycles", 5);
        check_hilo("multu", 32'h1, 32'hFFFFFFFE);

        // div / overflow / divide by zero
        issue(4'd2, 32'hFFFFFFF9, 32'h2);
        wait_idle("div_cycles", 10);
        check_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(4'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle("div_ovf_cycles", 10);
        check_hilo("div_ovf", 32'h0, 32'h80000000);
        issue(4'd3, 32'h12345678, 32'h0);
        wait_idle("divu0_cycles", 10);
        check_hilo("divu0", 32'h0, 32'h80000000);
        issue(4'd3, 32'd100, 32'd7);
        wait_idle("divu_cycles", 10);
        check_hilo("divu", 32'd2, 32'd14);

        // madd/msub accumulation
        issue(4'd6, 32'h0, 32'h0);
        issue(4'd7, 32'hFFFFFFFF, 32'h0);
        issue(4'd9, 32'h1, 32'h1);
        wait_idle("maddu_cycles", 5);
        check_hilo("maddu", 32'h1, 32'h0);
        issue(4'd10, 32'h1, 32'h2);
        wait_idle("msub_cycles", 5);
        check_hilo("msub", 32'h0, 32'hFFFFFFFE);

        // flush in busy cycle 3
        issue(4'd0, 32'h3, 32'h4);           // sample: busy cycle 1
        @(negedge clk);                      // busy cycle 2
        @(negedge clk);                      // busy cycle 3
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush3_busy", {31'b0, busy}, 32'h0);
        check_hilo("flush3", 32'h0, 32'hFFFFFFFE);
        repeat (4) @(negedge clk);
        check_hilo("flush3_later", 32'h0, 32'hFFFFFFFE);

        // flush on the completion edge
        issue(4'd0, 32'h3, 32'h4);
        repeat (4) @(negedge clk);           // busy cycle 5
        check("flush5_still_busy", {31'b0, busy}, 32'h1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush5_busy", {31'b0, busy}, 32'h0);
        check_hilo("flush5", 32'h0, 32'hFFFFFFFE);

        // mtlo while busy is ignored, mflo during busy returns old LO
        issue(4'd0, 32'h3, 32'h4);
        start = 1'b1; op = 4'd7; src_a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; op = 4'd15;
        read_mf("mflo_busy", 4'd5, 32'hFFFFFFFE);
        wait_idle("mult_rest_cycles", 4);
        check_hilo("mtlo_ignored", 32'h0, 32'd12);

        // back-to-back issue right after busy falls
        issue(4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("b2b_busy", {31'b0, busy}, 32'h1);
        wait_idle("b2b_cycles", 5);
        check_hilo("b2b", 32'h0, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
